// File: rtl/alu_issue_pkg.sv
// Shared types for alu_op_issuer: FSM state encoding, flag bit positions
// and the packed architectural flag record.
package alu_issue_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    RESP = 2'd3
  } state_t;

  // Bit positions inside the 4-bit {O, N, C, Z} flags output.
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_O = 3;

  // Field order keeps z at bit FLAG_Z so the low nibble maps onto flags.
  typedef struct packed {
    logic cmp;
    logic o;
    logic n;
    logic c;
    logic z;
  } alu_flags_t;

  function automatic logic [3:0] flag_nibble(input alu_flags_t f);
    logic [3:0] v;
    v         = '0;
    v[FLAG_Z] = f.z;
    v[FLAG_C] = f.c;
    v[FLAG_N] = f.n;
    v[FLAG_O] = f.o;
    return v;
  endfunction

endpackage

// File: rtl/alu_flag_reg.sv
// Architectural flag register (Z, C, N, O, CMP): loads on the update strobe,
// clears synchronously on rst.
module alu_flag_reg
  import alu_issue_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       upd,
  input  alu_flags_t d,
  output alu_flags_t q
);

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst)      q <= '0;
    else if (upd) q <= d;
  end

endmodule

// File: rtl/alu_op_issuer.sv
// Sequences 8-bit ALU cycles for decoded operations and returns results.
// Define WIDE16_EN to build the chained 16-bit (HI cycle) path.
module alu_op_issuer
  import alu_issue_pkg::*;
#(
  parameter int CINS_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CINS_W-1:0] req_cins,
  input  logic              req_wide,
  input  logic              req_use_c,
  input  logic [15:0]       req_a,
  input  logic [15:0]       req_b,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  output logic [CINS_W-1:0] alu_cins,
  output logic              alu_oe,
  output logic              alu_carryin,
  input  logic [7:0]        alu_result,
  input  logic              alu_carryout,
  input  logic              alu_overout,
  input  logic              alu_cmpo,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [15:0]       rsp_result,
  output logic [3:0]        flags,
  output logic              cmp_flag
);

`ifdef WIDE16_EN
  localparam int OPW = 16;
`else
  localparam int OPW = 8;
`endif

  state_t            state, state_next;
  logic [CINS_W-1:0] cins_q;
  logic              use_c_q;
  logic [OPW-1:0]    a_q, b_q;
  logic [7:0]        res_lo;
  logic              last_cycle;
  logic              lo_zero;
  alu_flags_t        flag_d, flag_q;

`ifdef WIDE16_EN
  logic              wide_q;
  logic              chain_c;
  logic [7:0]        res_hi;
`else
  logic              unused_hi;
  assign unused_hi = ^{req_wide, req_a[15:8], req_b[15:8]};
`endif

  // NOTE: operand and result registers are reset too, because rsp_result
  // must read 0 straight out of reset, not whatever powered up.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cins_q  <= '0;
      use_c_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_lo  <= '0;
`ifdef WIDE16_EN
      wide_q  <= 1'b0;
      chain_c <= 1'b0;
      res_hi  <= '0;
`endif
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (req_valid) begin
          cins_q  <= req_cins;
          use_c_q <= req_use_c;
          a_q     <= req_a[OPW-1:0];
          b_q     <= req_b[OPW-1:0];
`ifdef WIDE16_EN
          wide_q  <= req_wide;
`endif
        end
        LO: begin
          res_lo  <= alu_result;
`ifdef WIDE16_EN
          chain_c <= alu_carryout;
`endif
        end
`ifdef WIDE16_EN
        HI: res_hi <= alu_result;
`endif
        default: ;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_cins    = '0;
    alu_oe      = 1'b0;
    alu_carryin = 1'b0;
    last_cycle  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = LO;
      end
      LO: begin
        alu_a       = a_q[7:0];
        alu_b       = b_q[7:0];
        alu_cins    = cins_q;
        alu_oe      = 1'b1;
        alu_carryin = use_c_q & flag_q.c;
`ifdef WIDE16_EN
        last_cycle  = ~wide_q;
        state_next  = wide_q ? HI : RESP;
`else
        last_cycle  = 1'b1;
        state_next  = RESP;
`endif
      end
`ifdef WIDE16_EN
      HI: begin
        alu_a       = a_q[15:8];
        alu_b       = b_q[15:8];
        alu_cins    = cins_q;
        alu_oe      = 1'b1;
        alu_carryin = chain_c;
        last_cycle  = 1'b1;
        state_next  = RESP;
      end
`endif
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Zero flag covers the whole result: in HI the already-captured low byte counts.
  assign lo_zero = (state == HI) ? (res_lo == 8'h00) : 1'b1;

  always_comb begin
    flag_d     = '0;
    flag_d.c   = alu_carryout;
    flag_d.o   = alu_overout;
    flag_d.n   = alu_result[7];
    flag_d.cmp = alu_cmpo;
    flag_d.z   = lo_zero && (alu_result == 8'h00);
  end

  alu_flag_reg u_flag_reg (
    .clk (clk),
    .rst (rst),
    .upd (last_cycle),
    .d   (flag_d),
    .q   (flag_q)
  );

  assign flags    = flag_nibble(flag_q);
  assign cmp_flag = flag_q.cmp;

`ifdef WIDE16_EN
  assign rsp_result = {res_hi, res_lo};
`else
  assign rsp_result = {8'h00, res_lo};
`endif

endmodule
